// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the 5-stage MIPS pipeline: reset PC, bubble
// instruction, opcode/funct codes and instruction field positions used by the
// front-end registers, hazard unit and forwarding logic.
package mips_pipe_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    // Register field positions
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // Everything the D/E register carries, packed so one register cell holds it
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } de_regs_t;

    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/front_pipe_regs_if.sv
// Bundle between the front-end registers and the surrounding core: fetch
// address/data, hazard stall, D-stage next-PC decision and operands, and the
// F/D and D/E register outputs. The slave modport is the register block.
interface front_pipe_regs_if;

    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic        stall;
    logic        npc_sel_d;
    logic [31:0] npc_target_d;
    logic [31:0] rs_val_d;
    logic [31:0] rt_val_d;
    logic [31:0] imm_ext_d;
    logic [31:0] ir_d;
    logic [31:0] pc4_d;
    logic [31:0] ir_e;
    logic [31:0] pc4_e;
    logic [31:0] rs_val_e;
    logic [31:0] rt_val_e;
    logic [31:0] imm_e;

    modport master (
        output instr_f, stall, npc_sel_d, npc_target_d,
               rs_val_d, rt_val_d, imm_ext_d,
        input  pc_f, ir_d, pc4_d, ir_e, pc4_e, rs_val_e, rt_val_e, imm_e
    );

    modport slave (
        input  instr_f, stall, npc_sel_d, npc_target_d,
               rs_val_d, rt_val_d, imm_ext_d,
        output pc_f, ir_d, pc4_d, ir_e, pc4_e, rs_val_e, rt_val_e, imm_e
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset to RESET_VAL, synchronous
// clear to CLEAR_VAL (takes priority over enable), otherwise loads d when en=1.
module pipe_reg_en_clr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset, then clear-to-value, then load when enabled, else hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= CLEAR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/front_pipe_regs.sv
// Front end of the 5-stage MIPS core: PC, F/D and D/E registers.
// A stall holds PC and F/D and turns D/E into a bubble. Branches have a delay
// slot, so a taken branch only redirects the PC and never flushes F/D.
// Optional build macro FRONT_STALL_CNT_EN adds a saturating stall_cnt output.
module front_pipe_regs #(
    parameter logic [31:0] PC_RESET = mips_pipe_pkg::PC_RESET,
    parameter logic [31:0] NOP_WORD = mips_pipe_pkg::NOP_WORD
) (
    input  logic clk,
    input  logic reset_n,
    front_pipe_regs_if.slave bus
`ifdef FRONT_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    import mips_pipe_pkg::*;

    localparam logic [63:0]  FD_RESET = {NOP_WORD, 32'h0};
    localparam logic [159:0] DE_EMPTY = {NOP_WORD, 128'h0};

    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic [63:0] fd_q;
    de_regs_t    de_d;
    de_regs_t    de_q;

    // Target low bits are dropped so the PC can never become misaligned
    always_comb begin
        pc_plus4 = bus.pc_f + 32'd4;
        npc      = bus.npc_sel_d ? {bus.npc_target_d[31:2], 2'b00} : pc_plus4;
    end

    pipe_reg_en_clr #(
        .WIDTH    (32),
        .RESET_VAL(PC_RESET),
        .CLEAR_VAL(PC_RESET)
    ) u_pc (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (~bus.stall),
        .clr    (1'b0),
        .d      (npc),
        .q      (bus.pc_f)
    );

    pipe_reg_en_clr #(
        .WIDTH    (64),
        .RESET_VAL(FD_RESET),
        .CLEAR_VAL(FD_RESET)
    ) u_fd (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (~bus.stall),
        .clr    (1'b0),
        .d      ({bus.instr_f, pc_plus4}),
        .q      (fd_q)
    );

    // D/E input gathers the F/D contents with the forwarded D-stage operands
    always_comb begin
        de_d.ir     = fd_q[63:32];
        de_d.pc4    = fd_q[31:0];
        de_d.rs_val = bus.rs_val_d;
        de_d.rt_val = bus.rt_val_d;
        de_d.imm    = bus.imm_ext_d;
    end

    pipe_reg_en_clr #(
        .WIDTH    (160),
        .RESET_VAL(DE_EMPTY),
        .CLEAR_VAL(DE_EMPTY)
    ) u_de (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (1'b1),
        .clr    (bus.stall),
        .d      (de_d),
        .q      (de_q)
    );

    // Fan register contents back out onto the bus
    always_comb begin
        bus.ir_d     = fd_q[63:32];
        bus.pc4_d    = fd_q[31:0];
        bus.ir_e     = de_q.ir;
        bus.pc4_e    = de_q.pc4;
        bus.rs_val_e = de_q.rs_val;
        bus.rt_val_e = de_q.rt_val;
        bus.imm_e    = de_q.imm;
    end

`ifdef FRONT_STALL_CNT_EN
    // Count stalled edges, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'h0;
        end else if (bus.stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_front_pipe_regs.sv
// Scoreboard bench for front_pipe_regs: a reference model predicts every
// register after each edge, the prediction is queued when inputs are driven
// and popped for comparison one time unit after the rising edge.
// Honours FRONT_STALL_CNT_EN for the optional stall counter.
module tb_front_pipe_regs;

    typedef struct packed {
        logic [31:0] pc_f;
        logic [31:0] ir_d;
        logic [31:0] pc4_d;
        logic [31:0] ir_e;
        logic [31:0] pc4_e;
        logic [31:0] rs_val_e;
        logic [31:0] rt_val_e;
        logic [31:0] imm_e;
        logic [31:0] stall_cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    front_pipe_regs_if bus();
`ifdef FRONT_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    exp_t sb_q[$];
    exp_t m;
    int   n_checks;
    int   n_fail;

    front_pipe_regs dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef FRONT_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Instruction memory contents: a load at 0x300C, otherwise a word derived
    // from the address that is never the NOP word
    function automatic logic [31:0] im_word(input logic [31:0] addr);
        if (addr == 32'h0000_300C) return 32'h8C01_0000;
        return {~addr[15:0], addr[15:0]};
    endfunction

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory answering the DUT fetch address
    always_comb bus.instr_f = im_word(bus.pc_f);

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '0;
        m.pc_f = 32'h0000_3000;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, compare after edge
    task automatic apply_stimulus(input logic st, input logic sel,
                                  input logic [31:0] tgt, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [31:0] imm);
        logic [31:0] p4;
        exp_t        got;
        @(negedge clk);
        bus.stall        = st;
        bus.npc_sel_d    = sel;
        bus.npc_target_d = tgt;
        bus.rs_val_d     = rs;
        bus.rt_val_d     = rt;
        bus.imm_ext_d    = imm;
        p4 = m.pc_f + 32'd4;
        if (!st) begin
            m.ir_e     = m.ir_d;
            m.pc4_e    = m.pc4_d;
            m.rs_val_e = rs;
            m.rt_val_e = rt;
            m.imm_e    = imm;
            m.ir_d     = im_word(m.pc_f);
            m.pc4_d    = p4;
            m.pc_f     = sel ? {tgt[31:2], 2'b00} : p4;
        end else begin
            m.ir_e     = 32'h0;
            m.pc4_e    = 32'h0;
            m.rs_val_e = 32'h0;
            m.rt_val_e = 32'h0;
            m.imm_e    = 32'h0;
            if (m.stall_cnt != 32'hFFFF_FFFF) m.stall_cnt = m.stall_cnt + 32'd1;
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_output("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_output("pc_f",     bus.pc_f,     got.pc_f);
            check_output("ir_d",     bus.ir_d,     got.ir_d);
            check_output("pc4_d",    bus.pc4_d,    got.pc4_d);
            check_output("ir_e",     bus.ir_e,     got.ir_e);
            check_output("pc4_e",    bus.pc4_e,    got.pc4_e);
            check_output("rs_val_e", bus.rs_val_e, got.rs_val_e);
            check_output("rt_val_e", bus.rt_val_e, got.rt_val_e);
            check_output("imm_e",    bus.imm_e,    got.imm_e);
`ifdef FRONT_STALL_CNT_EN
            check_output("stall_cnt", stall_cnt,   got.stall_cnt);
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_pc_f"},  bus.pc_f,     32'h0000_3000);
        check_output({tag, "_ir_d"},  bus.ir_d,     32'h0);
        check_output({tag, "_pc4_d"}, bus.pc4_d,    32'h0);
        check_output({tag, "_ir_e"},  bus.ir_e,     32'h0);
        check_output({tag, "_pc4_e"}, bus.pc4_e,    32'h0);
        check_output({tag, "_rs_e"},  bus.rs_val_e, 32'h0);
        check_output({tag, "_imm_e"}, bus.imm_e,    32'h0);
`ifdef FRONT_STALL_CNT_EN
        check_output({tag, "_cnt"},   stall_cnt,    32'h0);
`endif
    endtask

    // Main sequence
    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset_n          = 1'b0;
        bus.stall        = 1'b0;
        bus.npc_sel_d    = 1'b0;
        bus.npc_target_d = 32'h0;
        bus.rs_val_d     = 32'h0;
        bus.rt_val_d     = 32'h0;
        bus.imm_ext_d    = 32'h0;
        model_reset();

        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("rst");
        #1 reset_n = 1'b1;

        // Sequential fetch
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h11, 32'h22, 32'h33);
        check_output("seq_pc1", bus.pc_f, 32'h0000_3004);
        check_output("seq_ird1", bus.ir_d, im_word(32'h0000_3000));
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h44, 32'h55, 32'h66);
        check_output("seq_pc2", bus.pc_f, 32'h0000_3008);
        check_output("seq_ire2", bus.ir_e, im_word(32'h0000_3000));
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h77, 32'h88, 32'h99);
        check_output("seq_pc3", bus.pc_f, 32'h0000_300C);

        // Load reaches F/D, then two stalls
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h1, 32'h2, 32'h3);
        check_output("lw_ird", bus.ir_d, 32'h8C01_0000);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h5, 32'h6);
        check_output("stall1_pc", bus.pc_f, 32'h0000_3010);
        check_output("stall1_ire", bus.ir_e, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h5, 32'h6);
        check_output("stall2_ird", bus.ir_d, 32'h8C01_0000);
        check_output("stall2_rse", bus.rs_val_e, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'hCAFE_0001, 32'h7, 32'h8);
        check_output("unstall_ire", bus.ir_e, 32'h8C01_0000);

        // Taken branch keeps the delay-slot instruction
        apply_stimulus(1'b0, 1'b1, 32'h0000_3040, 32'h0, 32'h0, 32'h0);
        check_output("br_pc", bus.pc_f, 32'h0000_3040);
        check_output("br_slot", bus.ir_d, im_word(32'h0000_3014));

        // Stall beats a branch, branch taken once stall drops
        apply_stimulus(1'b1, 1'b1, 32'h0000_3100, 32'h0, 32'h0, 32'h0);
        check_output("stbr_hold", bus.pc_f, 32'h0000_3040);
        apply_stimulus(1'b0, 1'b1, 32'h0000_3100, 32'h0, 32'h0, 32'h0);
        check_output("stbr_take", bus.pc_f, 32'h0000_3100);

        // Misaligned target bits ignored
        apply_stimulus(1'b0, 1'b1, 32'h0000_3103, 32'h0, 32'h0, 32'h0);
        check_output("align_pc", bus.pc_f, 32'h0000_3100);

        // PC+4 wraps at the top of the address space
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        check_output("top_pc", bus.pc_f, 32'hFFFF_FFFC);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        check_output("wrap_pc", bus.pc_f, 32'h0);
        check_output("wrap_pc4d", bus.pc4_d, 32'h0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                           $urandom, $urandom, $urandom, $urandom);
        end

        // Asynchronous reset in the middle of the high phase
        #2 reset_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        model_reset();
        reset_n = 1'b1;

        // Five stalls after reset
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0, 32'h9, 32'h9, 32'h9);
        end
        check_output("stall5_pc", bus.pc_f, 32'h0000_3000);
`ifdef FRONT_STALL_CNT_EN
        check_output("stall5_cnt", stall_cnt, 32'd5);
`endif
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'hA, 32'hB, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/front_pipe_regs.md
Name: front_pipe_regs

Overview:
- PC register plus F/D and D/E pipeline registers for the 5-stage MIPS core.
- Consumes the hazard unit's `stall`.
  - On stall: holds PC and F/D, and injects a NOP bubble into D/E.
  - Otherwise: advances PC to PC+4 or to the branch/jump target resolved in D.
- Branches use a MIPS delay slot, so a taken branch never flushes F/D.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset (word aligned).
- NOP_WORD, 32'h0000_0000, instruction word injected as a bubble (`sll $0,$0,0`).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr_f  in  32  instruction read from IM at pc_f (combinational in IM)
- pc_f  out  32  current fetch PC, drives IM address
- stall  in  1  from hazard unit; 1 = hold front end and bubble D/E
- npc_sel_d  in  1  D-stage branch taken or j/jal/jr
- npc_target_d  in  32  D-stage next-PC target
- rs_val_d  in  32  forwarded rs value in D
- rt_val_d  in  32  forwarded rt value in D
- imm_ext_d  in  32  extended immediate in D
- ir_d  out  32  F/D instruction
- pc4_d  out  32  F/D PC+4
- ir_e  out  32  D/E instruction
- pc4_e  out  32  D/E PC+4 (used for jal/bgezal link value PC+8 downstream)
- rs_val_e  out  32  D/E rs value
- rt_val_e  out  32  D/E rt value
- imm_e  out  32  D/E immediate

Behaviour:
- Reset (reset_n=0): asynchronous, takes effect immediately, including mid-cycle.
  - pc_f = PC_RESET; ir_d = ir_e = NOP_WORD.
  - pc4_d, pc4_e, rs_val_e, rt_val_e, imm_e = 0.
  - On release, the first rising edge performs a normal update.
- All registers update on the rising edge of clk only.
- Arithmetic: pc_plus4 = pc_f + 4, 32-bit unsigned; 0xFFFF_FFFC wraps to 0x0000_0000.
- Next PC: npc = npc_sel_d ? {npc_target_d[31:2],2'b00} : pc_plus4. Target bits [1:0] are ignored, so PC is always word aligned.
- Per edge, stall=0:
  - pc_f <= npc
  - ir_d <= instr_f; pc4_d <= pc_plus4
  - ir_e <= ir_d; pc4_e <= pc4_d; rs_val_e <= rs_val_d; rt_val_e <= rt_val_d; imm_e <= imm_ext_d
- Per edge, stall=1:
  - pc_f, ir_d, pc4_d hold.
  - ir_e <= NOP_WORD; pc4_e, rs_val_e, rt_val_e, imm_e <= 0.
- stall=1 and npc_sel_d=1 together: stall wins and the PC holds. The branch stays in D, is re-evaluated next cycle, and is taken when stall drops.
- Delay slot: a branch in D with npc_sel_d=1 and stall=0 still latches instr_f (the slot instruction) into F/D.
- Consecutive stalls: each stalled cycle inserts one bubble. F/D stays unchanged for the whole run.
- Latency: an instruction fetched at PC reaches ir_e two unstalled edges later.
- No handshake on IM; instr_f is assumed valid in the same cycle as pc_f.

Optional Feature:
- Macro: FRONT_STALL_CNT_EN.
- Defined:
  - Adds output `stall_cnt` [31:0], reset to 0 by reset_n.
  - Increments by 1 on each edge with stall=1.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `mips_pipe_pkg`: PC_RESET and NOP_WORD constants, opcode/funct constants, and the instruction field ranges rs/rt/rd shared with the hazard and forwarding logic.
- One natural sub-module, `pipe_reg_en_clr`: a parameterised-width register with async active-low reset, enable (hold) and synchronous clear-to-value.
  - F/D instance: enable = ~stall.
  - D/E instance: clear = stall.
  - PC uses the same cell.

Test Plan:
- Reset release, stall=0, npc_sel_d=0 for 3 edges:
  - pc_f = 0x3000 → 0x3004 → 0x3008 → 0x300C.
  - ir_d follows instr_f one edge later; ir_e follows two edges later.
- ir_d=0x8C010000 (lw), stall=1 for 2 edges:
  - pc_f and ir_d unchanged; ir_e=0 and rs_val_e=0 on both edges.
  - After stall drops, ir_e = 0x8C010000.
- npc_sel_d=1, npc_target_d=0x3040, stall=0 at pc_f=0x3008:
  - Next pc_f = 0x3040.
  - ir_d = delay-slot word fetched at 0x3008, not flushed.
- stall=1 and npc_sel_d=1 with target 0x3100 for 1 edge, then stall=0:
  - pc_f holds on the first edge, then becomes 0x3100.
- npc_target_d = 0x0000_3103:
  - pc_f = 0x0000_3100.
- Assert reset_n low mid-cycle after 10 edges:
  - pc_f = 0x3000 and ir_d = ir_e = 0 immediately, without a clk edge.
  - With FRONT_STALL_CNT_EN defined: stall_cnt returns to 0.
  - Separately, 5 stall cycles give stall_cnt = 5.
